// File: rtl/secded16_encoder_if.sv
// secded16_encoder_if
//   Handshake and bus bundle for the SEC/DED encoder.
//   master : producer/consumer side (drives in_*, inj_*, out_ready)
//   slave  : encoder side (drives in_ready, out_*, inj_pend, word_cnt)
//   Signals:
//     in_valid/in_ready/in_data[15:0]      write-side data handshake
//     inj_arm/inj_mask[21:0]               one-shot codeword corruption request
//     out_valid/out_ready/out_cw[21:0]     codeword handshake
//     out_inj                              current out_cw carries an injected mask
//     inj_pend                             armed mask waiting for a word
//     word_cnt[CNT_W-1:0]                  emitted codewords, wrapping
interface secded16_encoder_if #(
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_data;
   logic             inj_arm;
   logic [21:0]      inj_mask;
   logic             out_valid;
   logic             out_ready;
   logic [21:0]      out_cw;
   logic             out_inj;
   logic             inj_pend;
   logic [CNT_W-1:0] word_cnt;

   modport master (
      output in_valid, in_data, inj_arm, inj_mask, out_ready,
      input  in_ready, out_valid, out_cw, out_inj, inj_pend, word_cnt
   );

   modport slave (
      input  in_valid, in_data, inj_arm, inj_mask, out_ready,
      output in_ready, out_valid, out_cw, out_inj, inj_pend, word_cnt
   );
endinterface

// File: rtl/secded16_encoder.sv
// secded16_encoder
//   Two-stage pipelined extended-Hamming (22,16) SEC/DED encoder with a
//   one-shot error-injection path for exercising the decoder side.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset
//     bus  secded16_encoder_if.slave (valid/ready in and out, injection,
//          inj_pend status, word_cnt)
//   Codeword: cw[i], i=1..21 is Hamming position i; check bits at 1,2,4,8,16,
//   data d0..d15 fill the remaining positions in ascending order; cw[0] makes
//   the whole word even parity. The injection mask is XORed on last.
module secded16_encoder #(
   parameter int CNT_W  = 16,
   parameter bit INJ_EN = 1'b1
) (
   input logic                  clk,
   input logic                  rst,
   secded16_encoder_if.slave    bus
);

   typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} inj_st_e;

   // Scatter data bits into their Hamming positions (check positions left 0).
   function automatic logic [21:0] place_data(input logic [15:0] d);
      logic [21:0] v;
      int          j;
      v = '0;
      j = 0;
      for (int p = 1; p < 22; p++) begin
         if ((p & (p - 1)) != 0) begin
            v[p] = d[j];
            j++;
         end
      end
      return v;
   endfunction

   // Check bit k covers every data position whose index has bit k set.
   function automatic logic [4:0] check_bits(input logic [15:0] d);
      logic [21:0] v;
      logic [4:0]  c;
      v = place_data(d);
      c = '0;
      for (int k = 0; k < 5; k++) begin
         for (int p = 1; p < 22; p++) begin
            if ((p & (1 << k)) != 0) c[k] = c[k] ^ v[p];
         end
      end
      return c;
   endfunction

   // Pipeline state
   logic             s1_valid_q;
   logic [15:0]      s1_data_q;
   logic [4:0]       s1_chk_q;
   logic [21:0]      s1_mask_q;
   logic             s1_inj_q;
   logic             out_valid_q;
   logic [21:0]      out_cw_q;
   logic             out_inj_q;
   logic [CNT_W-1:0] word_cnt_q;

   // Injection state
   inj_st_e          state_q;
   logic [21:0]      mask_q;

   logic             s2_adv, s1_adv, in_hs, out_hs;
   logic [21:0]      acc_mask_d;
   logic             acc_inj_d;
   logic [21:0]      cw_clean_d;

   assign s2_adv = !out_valid_q || bus.out_ready;
   assign s1_adv = !s1_valid_q || s2_adv;
   assign in_hs  = bus.in_valid && s1_adv;
   assign out_hs = out_valid_q && bus.out_ready;

   // Mask that rides with a word accepted this cycle. A same-cycle arm wins
   // over a previously latched mask, so the freshest request is honoured.
   always_comb begin
      acc_mask_d = '0;
      acc_inj_d  = 1'b0;
      if (INJ_EN) begin
         if (bus.inj_arm) begin
            acc_mask_d = bus.inj_mask;
            acc_inj_d  = 1'b1;
         end else if (state_q == ARMED) begin
            acc_mask_d = mask_q;
            acc_inj_d  = 1'b1;
         end
      end
   end

   // Stage-2 assembly: overall parity is taken over the clean word only.
   always_comb begin
      cw_clean_d     = place_data(s1_data_q);
      cw_clean_d[1]  = s1_chk_q[0];
      cw_clean_d[2]  = s1_chk_q[1];
      cw_clean_d[4]  = s1_chk_q[2];
      cw_clean_d[8]  = s1_chk_q[3];
      cw_clean_d[16] = s1_chk_q[4];
      cw_clean_d[0]  = ^cw_clean_d[21:1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_chk_q    <= '0;
         s1_mask_q   <= '0;
         s1_inj_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_cw_q    <= '0;
         out_inj_q   <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid_q <= bus.in_valid;
            if (in_hs) begin
               s1_data_q <= bus.in_data;
               s1_chk_q  <= check_bits(bus.in_data);
               s1_mask_q <= acc_mask_d;
               s1_inj_q  <= acc_inj_d;
            end
         end
         if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_cw_q  <= cw_clean_d ^ s1_mask_q;
               out_inj_q <= s1_inj_q;
            end
         end
         if (out_hs) word_cnt_q <= word_cnt_q + 1'b1;
      end
   end

   // Injection FSM: an accepted word always consumes the arm, even one
   // raised in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         mask_q  <= '0;
      end else if (INJ_EN) begin
         if (in_hs) begin
            state_q <= IDLE;
            mask_q  <= '0;
         end else if (bus.inj_arm) begin
            state_q <= ARMED;
            mask_q  <= bus.inj_mask;
         end
      end
   end

   assign bus.in_ready  = s1_adv;
   assign bus.out_valid = out_valid_q;
   assign bus.out_cw    = out_cw_q;
   assign bus.out_inj   = out_inj_q;
   assign bus.inj_pend  = (state_q == ARMED);
   assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_secded16_encoder.sv
module tb_secded16_encoder;
   localparam int CNT_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   secded16_encoder_if #(.CNT_W(CNT_W)) bus ();
   secded16_encoder #(.CNT_W(CNT_W), .INJ_EN(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      logic [21:0] cw;
      logic        inj;
   } exp_t;

   exp_t        q[$];
   int          errs = 0;
   int          checks = 0;
   int          in_cnt = 0;
   int          out_cnt = 0;
   int          ref_cnt = 0;
   bit          armed = 0;
   logic [21:0] amask = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s obs=%h exp=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference: check value = XOR of the indices of all set data positions,
   // which is exactly what makes the received syndrome zero.
   function automatic logic [21:0] ref_cw(input logic [15:0] d, input logic [21:0] m);
      logic [21:0] v;
      int          s, j;
      v = '0; s = 0; j = 0;
      for (int p = 1; p <= 21; p++) begin
         if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16) begin
            v[p] = d[j];
            if (d[j]) s = s ^ p;
            j++;
         end
      end
      for (int k = 0; k < 5; k++) v[1 << k] = s[k];
      v[0] = ($countones(v) % 2) == 1;
      return v ^ m;
   endfunction

   // Scoreboard / monitor, sampled away from the active edge.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) chk("cw_spurious", 1, 0);
            else begin
               e = q.pop_front();
               chk("cw", {10'd0, bus.out_cw}, {10'd0, e.cw});
               chk("inj", {31'd0, bus.out_inj}, {31'd0, e.inj});
               if (!e.inj) chk("parity", {31'd0, ^bus.out_cw}, 0);
            end
            chk("word_cnt", {28'd0, bus.word_cnt}, ref_cnt);
            ref_cnt = (ref_cnt + 1) % (1 << CNT_W);
            out_cnt++;
         end
         if (bus.in_valid && bus.in_ready) begin
            if (bus.inj_arm) begin
               e.cw = ref_cw(bus.in_data, bus.inj_mask); e.inj = 1;
            end else if (armed) begin
               e.cw = ref_cw(bus.in_data, amask); e.inj = 1;
            end else begin
               e.cw = ref_cw(bus.in_data, '0); e.inj = 0;
            end
            q.push_back(e);
            armed = 0;
            in_cnt++;
         end else if (bus.inj_arm) begin
            armed = 1;
            amask = bus.inj_mask;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.in_valid = 0; bus.inj_arm = 0; bus.out_ready = 1;
      while ((q.size() != 0 || bus.out_valid) && n < 50) begin
         cyc();
         n++;
      end
      chk("drain", q.size(), 0);
   endtask

   initial begin
      logic [21:0] held;
      int          i0, n, a, b;
      bus.in_valid = 0; bus.in_data = '0; bus.inj_arm = 0; bus.inj_mask = '0; bus.out_ready = 1;
      #2;
      chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
      chk("rst_out_cw", {10'd0, bus.out_cw}, 0);
      chk("rst_out_inj", {31'd0, bus.out_inj}, 0);
      chk("rst_inj_pend", {31'd0, bus.inj_pend}, 0);
      chk("rst_word_cnt", {28'd0, bus.word_cnt}, 0);
      cyc();
      cyc();
      rst = 0;

      // 1: directed back-to-back words and latency
      chk("t1_in_ready", {31'd0, bus.in_ready}, 1);
      bus.in_valid = 1; bus.in_data = 16'h0000;
      cyc();
      chk("t1_lat_ov0", {31'd0, bus.out_valid}, 0);
      bus.in_data = 16'h0001;
      cyc();
      chk("t1_ov1", {31'd0, bus.out_valid}, 1);
      chk("t1_cw0", {10'd0, bus.out_cw}, 32'h000000);
      bus.in_data = 16'hFFFF;
      cyc();
      chk("t1_cw1", {10'd0, bus.out_cw}, 32'h00000F);
      bus.in_valid = 0;
      cyc();
      chk("t1_cw2", {10'd0, bus.out_cw}, 32'h3FFFFC);
      cyc();
      chk("t1_cnt", {28'd0, bus.word_cnt}, 3);
      drain();

      // 3: injection, same-cycle arm and separately armed
      bus.in_valid = 1; bus.in_data = 16'h0001; bus.inj_arm = 1; bus.inj_mask = 22'h000008;
      cyc();
      bus.inj_arm = 0;
      chk("t3_pend_clr", {31'd0, bus.inj_pend}, 0);
      cyc();
      chk("t3_cw_inj", {10'd0, bus.out_cw}, 32'h000007);
      chk("t3_out_inj", {31'd0, bus.out_inj}, 1);
      bus.in_valid = 0;
      cyc();
      chk("t3_clean_inj", {31'd0, bus.out_inj}, 0);
      drain();
      bus.inj_arm = 1; bus.inj_mask = 22'h200000;
      cyc();
      bus.inj_arm = 0;
      chk("t3_pend_set", {31'd0, bus.inj_pend}, 1);
      bus.in_valid = 1; bus.in_data = 16'hBEEF;
      cyc();
      bus.in_valid = 0;
      chk("t3_pend_acc", {31'd0, bus.inj_pend}, 0);
      drain();

      // 4: backpressure
      i0 = in_cnt;
      bus.out_ready = 0; bus.in_valid = 1;
      for (int c = 0; c < 5; c++) begin
         bus.in_data = 16'hA000 + 16'(in_cnt);
         cyc();
      end
      chk("t4_accepted", in_cnt - i0, 2);
      chk("t4_in_ready", {31'd0, bus.in_ready}, 0);
      held = bus.out_cw;
      cyc();
      chk("t4_stable", {10'd0, bus.out_cw}, {10'd0, held});
      drain();

      // 2: exhaustive data space
      bus.out_ready = 1; bus.in_valid = 1;
      for (int d = 0; d < 65536; d++) begin
         bus.in_data = 16'(d);
         cyc();
      end
      drain();

      // 5: random valid/ready with 2-bit injection masks
      i0 = in_cnt; n = 0;
      while (in_cnt - i0 < 4000 && n < 20000) begin
         bus.in_valid  = ($urandom % 4) != 0;
         bus.in_data   = 16'($urandom);
         bus.out_ready = ($urandom % 4) != 0;
         bus.inj_arm   = ($urandom % 40) == 0;
         a = $urandom_range(0, 21); b = $urandom_range(0, 21);
         bus.inj_mask  = (22'd1 << a) | (22'd1 << b);
         cyc();
         n++;
      end
      chk("t5_budget", (in_cnt - i0 >= 4000) ? 1 : 0, 1);
      drain();
      chk("t5_cnt_wrap", {28'd0, bus.word_cnt}, out_cnt % (1 << CNT_W));

      // 6: async reset with both stages full and armed
      bus.out_ready = 0; bus.in_valid = 1; bus.in_data = 16'h1234;
      cyc();
      bus.in_data = 16'h5678;
      cyc();
      bus.in_valid = 0; bus.inj_arm = 1; bus.inj_mask = 22'h000003;
      cyc();
      bus.inj_arm = 0;
      chk("t6_full", {31'd0, bus.in_ready}, 0);
      chk("t6_armed", {31'd0, bus.inj_pend}, 1);
      #2 rst = 1;
      #1;
      chk("t6_ov", {31'd0, bus.out_valid}, 0);
      chk("t6_pend", {31'd0, bus.inj_pend}, 0);
      chk("t6_cnt", {28'd0, bus.word_cnt}, 0);
      chk("t6_cw", {10'd0, bus.out_cw}, 0);
      q.delete(); armed = 0; ref_cnt = 0;
      cyc();
      rst = 0;
      chk("t6_in_ready", {31'd0, bus.in_ready}, 1);
      bus.out_ready = 1; bus.in_valid = 1; bus.in_data = 16'h0001;
      cyc();
      bus.in_valid = 0;
      cyc();
      chk("t6_post_cw", {10'd0, bus.out_cw}, 32'h00000F);
      chk("t6_post_inj", {31'd0, bus.out_inj}, 0);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
